// File: rtl/loadblock_gather_pkg.sv
// Shared constants, FSM state type and scalar-load helpers for loadblock_gather.
package loadblock_gather_pkg;

  // Banks / vector elements; the datapath is built around exactly four.
  localparam int LANES = 4;

  // load_select encodings
  localparam logic [1:0] LS_LB = 2'd0;
  localparam logic [1:0] LS_LH = 2'd1;
  localparam logic [1:0] LS_LW = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_RESP    = 2'd3
  } state_t;

  // A scalar access is misaligned when it crosses its natural boundary
  // or uses the reserved load_select code.
  function automatic logic is_misaligned(input logic [1:0] sel, input logic [1:0] off);
    logic mis;
    case (sel)
      LS_LB:   mis = 1'b0;
      LS_LH:   mis = off[0];
      LS_LW:   mis = (off != 2'd0);
      default: mis = 1'b1;
    endcase
    return mis;
  endfunction

  // Shift the bank word down to the addressed byte, then truncate and extend.
  // Zero-extension only applies to byte and halfword loads.
  function automatic logic [31:0] extract_scalar(input logic [31:0] word,
                                                 input logic [1:0]  sel,
                                                 input logic [1:0]  off,
                                                 input logic        uns);
    logic [31:0] w;
    logic [31:0] r;
    w = word >> {off, 3'b000};
    case (sel)
      LS_LB:   r = uns ? {24'd0, w[7:0]}  : {{24{w[7]}}, w[7:0]};
      LS_LH:   r = uns ? {16'd0, w[15:0]} : {{16{w[15]}}, w[15:0]};
      default: r = w;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/loadblock_gather_if.sv
// Request/response and data-memory bank bundle for loadblock_gather.
// master = requester plus memory side, slave = the gather block.
import loadblock_gather_pkg::*;

interface loadblock_gather_if #(
  parameter int AW = 12
);
  // request
  logic                           req_valid;
  logic                           req_ready;
  logic                           is_vltype;
  logic [1:0]                     load_select;
  logic                           load_unsigned;
  logic [1:0]                     byte_offset;
  logic [LANES-1:0][AW-1:0]       data_addr;
  // data-memory banks
  logic [LANES-1:0]               dm_ren;
  logic [LANES-1:0][AW-3:0]       dm_raddr;
  logic [LANES-1:0][31:0]         dm_rdata;
  // response
  logic                           resp_valid;
  logic                           resp_misaligned;
  logic [LANES-1:0][31:0]         data_out;

  modport master (
    output req_valid, is_vltype, load_select, load_unsigned, byte_offset, data_addr, dm_rdata,
    input  req_ready, dm_ren, dm_raddr, resp_valid, resp_misaligned, data_out
  );

  modport slave (
    input  req_valid, is_vltype, load_select, load_unsigned, byte_offset, data_addr, dm_rdata,
    output req_ready, dm_ren, dm_raddr, resp_valid, resp_misaligned, data_out
  );

endinterface

// File: rtl/loadblock_gather_load_bank_arbiter.sv
// Combinational bank arbiter: each bank is granted to the lowest-index
// pending element that maps onto it.
import loadblock_gather_pkg::*;

module load_bank_arbiter (
  input  logic [LANES-1:0]       pending,
  input  logic [LANES-1:0][1:0]  bank_sel,
  output logic [LANES-1:0]       grant,
  output logic [LANES-1:0]       bank_hit,
  output logic [LANES-1:0][1:0]  bank_idx
);

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_bank
      logic       hit_g;
      logic [1:0] idx_g;

      // Scan from the top down so the lowest matching index wins.
      always_comb begin
        hit_g = 1'b0;
        idx_g = 2'd0;
        for (int i = LANES - 1; i >= 0; i--) begin
          if (pending[i] && (bank_sel[i] == 2'(gi))) begin
            hit_g = 1'b1;
            idx_g = 2'(i);
          end
        end
      end

      assign bank_hit[gi] = hit_g;
      assign bank_idx[gi] = idx_g;
    end

    for (gi = 0; gi < LANES; gi++) begin : g_grant
      // An element is granted when its bank chose it.
      assign grant[gi] = pending[gi] && bank_hit[bank_sel[gi]] &&
                         (bank_idx[bank_sel[gi]] == 2'(gi));
    end
  endgenerate

endmodule

// File: rtl/loadblock_gather.sv
// Load gather unit: issues scalar or 4-element vector reads to the banked
// data memory, serialises bank conflicts over rounds, and returns extended
// scalar data or the gathered words.
import loadblock_gather_pkg::*;

module loadblock_gather #(
  parameter int AW = 12
) (
  input  logic              clk,
  input  logic              rst,
  loadblock_gather_if.slave bus
);

  state_t                    state_reg;
  logic [LANES-1:0]          pending_reg;
  logic                      is_vec_reg;
  logic [1:0]                sel_reg;
  logic                      uns_reg;
  logic [1:0]                off_reg;
  logic                      mis_reg;
  logic [LANES-1:0][AW-1:0]  addr_reg;
  logic [LANES-1:0][31:0]    elem_reg;
  logic [LANES-1:0][31:0]    data_out_reg;
  logic                      req_ready_reg;
  logic                      resp_valid_reg;
  logic                      resp_mis_reg;

  logic [LANES-1:0][1:0]     bank_sel;
  logic [LANES-1:0]          grant;
  logic [LANES-1:0]          bank_hit;
  logic [LANES-1:0][1:0]     bank_idx;
  logic [LANES-1:0][31:0]    elem_next;
  logic [LANES-1:0]          pending_next;
  logic [LANES-1:0][31:0]    resp_data;

  load_bank_arbiter u_arb (
    .pending  (pending_reg),
    .bank_sel (bank_sel),
    .grant    (grant),
    .bank_hit (bank_hit),
    .bank_idx (bank_idx)
  );

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign bank_sel[gi] = addr_reg[gi][1:0];

      // Bank read port: only during ISSUE, never for a misaligned scalar.
      assign bus.dm_ren[gi]   = (state_reg == ST_ISSUE) && bank_hit[gi] && !mis_reg;
      assign bus.dm_raddr[gi] = bus.dm_ren[gi] ? addr_reg[bank_idx[gi]][AW-1:2] : '0;

      // Read data arrives in CAPTURE, routed back from the element's bank.
      assign elem_next[gi] = ((state_reg == ST_CAPTURE) && grant[gi]) ?
                             bus.dm_rdata[bank_sel[gi]] : elem_reg[gi];

      // Vector returns all words; scalar returns only element 0, extracted.
      if (gi == 0) begin : g_scalar
        assign resp_data[gi] = is_vec_reg ? elem_next[gi] :
                               mis_reg    ? 32'd0 :
                               extract_scalar(elem_next[gi], sel_reg, off_reg, uns_reg);
      end else begin : g_vec
        assign resp_data[gi] = is_vec_reg ? elem_next[gi] : 32'd0;
      end
    end
  endgenerate

  assign pending_next = pending_reg & ~grant;

  // Request/round/response sequencing with registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      pending_reg    <= '0;
      is_vec_reg     <= 1'b0;
      sel_reg        <= 2'd0;
      uns_reg        <= 1'b0;
      off_reg        <= 2'd0;
      mis_reg        <= 1'b0;
      addr_reg       <= '0;
      elem_reg       <= '0;
      data_out_reg   <= '0;
      req_ready_reg  <= 1'b1;
      resp_valid_reg <= 1'b0;
      resp_mis_reg   <= 1'b0;
    end else begin
      resp_valid_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (bus.req_valid && req_ready_reg) begin
            is_vec_reg    <= bus.is_vltype;
            sel_reg       <= bus.load_select;
            uns_reg       <= bus.load_unsigned;
            off_reg       <= bus.byte_offset;
            mis_reg       <= !bus.is_vltype && is_misaligned(bus.load_select, bus.byte_offset);
            addr_reg      <= bus.data_addr;
            pending_reg   <= bus.is_vltype ? 4'b1111 : 4'b0001;
            elem_reg      <= '0;
            data_out_reg  <= '0;
            req_ready_reg <= 1'b0;
            state_reg     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          state_reg <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          elem_reg    <= elem_next;
          pending_reg <= pending_next;
          if (pending_next == '0) begin
            data_out_reg   <= resp_data;
            resp_valid_reg <= 1'b1;
            resp_mis_reg   <= mis_reg;
            state_reg      <= ST_RESP;
          end else begin
            state_reg <= ST_ISSUE;
          end
        end
        default: begin
          resp_mis_reg  <= 1'b0;
          req_ready_reg <= 1'b1;
          state_reg     <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready       = req_ready_reg;
  assign bus.resp_valid      = resp_valid_reg;
  assign bus.resp_misaligned = resp_mis_reg;
  assign bus.data_out        = data_out_reg;

endmodule
